// File: rtl/sr_trace_buffer.sv
// Retire-trace capture unit: records {cycle, pc, instr, a0} per executed instruction
// into a FIFO drained over valid/ready, and stops the run on a cycle limit or PC breakpoint.
module sr_trace_buffer #(
    parameter int DEPTH         = 16,
    parameter int CYCLE_LIMIT   = 120,
    parameter bit STALL_ON_FULL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        clear,
    input  logic        cpu_step,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_instr,
    input  logic [31:0] cpu_a0,
    input  logic        bp_en,
    input  logic [31:0] bp_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_cycle,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_a0,
    output logic        halt_req,
    output logic        running,
    output logic        timeout,
    output logic        bp_hit,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = 16 + 32 + 32 + 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cycle_q, cycle_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            timeout_q, timeout_d;
    logic            bp_hit_q, bp_hit_d;
    logic            overflow_q, overflow_d;
    logic [RW-1:0]   mem_q [DEPTH];

    logic            full_s;
    logic            push_req_s;
    logic            push_acc_s;
    logic            pop_s;
    logic            hit_limit_s;
    logic            hit_bp_s;

    assign full_s      = (count_q == (AW+1)'(DEPTH));
    assign out_valid   = (count_q != {(AW+1){1'b0}});
    assign halt_req    = (state_q != ST_RUN) || (STALL_ON_FULL && full_s);
    assign running     = (state_q == ST_RUN);
    assign timeout     = timeout_q;
    assign bp_hit      = bp_hit_q;
    assign overflow    = overflow_q;
    assign {out_cycle, out_pc, out_instr, out_a0} = mem_q[rd_ptr_q];

    // A push attempt happens on every unfrozen step; when full (drop mode) it is
    // accepted only if a pop frees the head slot in the same cycle.
    assign pop_s       = out_valid && out_ready;
    assign push_req_s  = (state_q == ST_RUN) && cpu_step && !halt_req;
    assign push_acc_s  = push_req_s && (!full_s || pop_s);
    assign hit_limit_s = (cycle_q == 16'(CYCLE_LIMIT - 1));
    assign hit_bp_s    = bp_en && (cpu_pc == bp_pc);

    // Next-state logic for run control, cycle counter, FIFO pointers and sticky flags
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        timeout_d  = timeout_q;
        bp_hit_d   = bp_hit_q;
        overflow_d = overflow_q;
        if (clear) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = {AW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            count_d    = {(AW+1){1'b0}};
            timeout_d  = 1'b0;
            bp_hit_d   = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_RUN;
                        cycle_d = 16'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (push_req_s) begin
                        cycle_d = cycle_q + 16'd1;
                        if (hit_limit_s) begin
                            timeout_d = 1'b1;
                        end else begin
                            timeout_d = timeout_q;
                        end
                        if (hit_bp_s) begin
                            bp_hit_d = 1'b1;
                        end else begin
                            bp_hit_d = bp_hit_q;
                        end
                        if (hit_limit_s || hit_bp_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
            if (push_acc_s) begin
                wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (AW+1)'(push_acc_s) - (AW+1)'(pop_s);
            if (push_req_s && !push_acc_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cycle_q    <= 16'd0;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            timeout_q  <= 1'b0;
            bp_hit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
            bp_hit_q   <= bp_hit_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage; only entry 0 (the head after a flush) is zeroed so out_* read 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mem_q[0] <= {RW{1'b0}};
        end else if (push_acc_s) begin
            mem_q[wr_ptr_q] <= {cycle_q, cpu_pc, cpu_instr, cpu_a0};
        end
    end

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Bench for sr_trace_buffer: four instances with different parameters share one stimulus
// stream and are compared against a queue-based reference model.
module tb_sr_trace_buffer;

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a0;
    } rec_t;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst, arm, clear, cpu_step, bp_en;
    logic [31:0] cpu_pc, cpu_instr, cpu_a0, bp_pc;
    logic        rdy  [N];
    logic        ov   [N];
    logic [15:0] ocyc [N];
    logic [31:0] opc  [N];
    logic [31:0] oins [N];
    logic [31:0] oa0  [N];
    logic        halt [N];
    logic        run  [N];
    logic        tmo  [N];
    logic        bph  [N];
    logic        ovf  [N];

    int checks = 0;
    int errors = 0;

    // model state: 0 idle, 1 run, 2 done
    int          m_st  [N];
    logic [15:0] m_cyc [N];
    bit          m_to  [N];
    bit          m_bp  [N];
    bit          m_ov  [N];
    rec_t        mq    [N][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sr_trace_buffer #(
            .DEPTH        ((g >= 2) ? 4 : 16),
            .CYCLE_LIMIT  ((g == 1) ? 5 : 120),
            .STALL_ON_FULL((g == 3) ? 1'b0 : 1'b1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .arm      (arm),
            .clear    (clear),
            .cpu_step (cpu_step),
            .cpu_pc   (cpu_pc),
            .cpu_instr(cpu_instr),
            .cpu_a0   (cpu_a0),
            .bp_en    (bp_en),
            .bp_pc    (bp_pc),
            .out_valid(ov[g]),
            .out_ready(rdy[g]),
            .out_cycle(ocyc[g]),
            .out_pc   (opc[g]),
            .out_instr(oins[g]),
            .out_a0   (oa0[g]),
            .halt_req (halt[g]),
            .running  (run[g]),
            .timeout  (tmo[g]),
            .bp_hit   (bph[g]),
            .overflow (ovf[g])
        );
    end

    function automatic int p_depth(input int k);
        return (k >= 2) ? 4 : 16;
    endfunction

    function automatic int p_limit(input int k);
        return (k == 1) ? 5 : 120;
    endfunction

    function automatic bit p_stall(input int k);
        return (k == 3) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit m_halt(input int k);
        return (m_st[k] != 1) || (p_stall(k) && (mq[k].size() == p_depth(k)));
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            bit h, pop, preq;
            h    = m_halt(k);
            pop  = (mq[k].size() > 0) && rdy[k];
            preq = (m_st[k] == 1) && cpu_step && !h;
            if (rst || clear) begin
                mq[k].delete();
                m_st[k] = 0;
                m_to[k] = 1'b0;
                m_bp[k] = 1'b0;
                m_ov[k] = 1'b0;
                if (rst) m_cyc[k] = 16'd0;
            end else begin
                if (pop) void'(mq[k].pop_front());
                if (preq) begin
                    if (mq[k].size() < p_depth(k))
                        mq[k].push_back('{m_cyc[k], cpu_pc, cpu_instr, cpu_a0});
                    else
                        m_ov[k] = 1'b1;
                    if (m_cyc[k] == 16'(p_limit(k) - 1)) begin
                        m_to[k] = 1'b1;
                        m_st[k] = 2;
                    end
                    if (bp_en && (cpu_pc == bp_pc)) begin
                        m_bp[k] = 1'b1;
                        m_st[k] = 2;
                    end
                    m_cyc[k] = m_cyc[k] + 16'd1;
                end else if ((m_st[k] == 0) && arm) begin
                    m_st[k]  = 1;
                    m_cyc[k] = 16'd0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        cpu_step = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        arm   = 1'b1; tick(); arm   = 1'b0;
    endtask

    task automatic set_step(input logic [31:0] pc);
        cpu_step  = 1'b1;
        cpu_pc    = pc;
        cpu_instr = $urandom;
        cpu_a0    = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || halt[k] !== 1'b1 || run[k] !== 1'b0 ||
                tmo[k] !== 1'b0 || bph[k] !== 1'b0 || ovf[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctl dut%0d got v%b h%b r%b t%b b%b o%b want v0 h1 r0 t0 b0 o0",
                         k, ov[k], halt[k], run[k], tmo[k], bph[k], ovf[k]);
            end
            checks++;
            if ({ocyc[k], opc[k], oins[k], oa0[k]} !== 112'd0) begin
                errors++;
                $display("FAIL reset_data dut%0d got %h want 0", k, {ocyc[k], opc[k], oins[k], oa0[k]});
            end
        end
    endtask

    task automatic test_basic();
        rdy[0] = 1'b1;
        restart();
        for (int i = 0; i < 10; i++) begin
            set_step(32'(i * 4));
            checks++;
            if (halt[0] !== 1'b0 || run[0] !== 1'b1) begin
                errors++;
                $display("FAIL basic_run step%0d got halt %b running %b want 0 1", i, halt[0], run[0]);
            end
            tick();
            checks++;
            if (ov[0] !== 1'b1 || ocyc[0] !== 16'(i) || opc[0] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL basic_head step%0d got v%b cyc %0d pc %h want v1 cyc %0d pc %h",
                         i, ov[0], ocyc[0], opc[0], i, i * 4);
            end
            checks++;
            if (mq[0].size() != 1 || {ocyc[0], opc[0], oins[0], oa0[0]} !== mq[0][0]) begin
                errors++;
                $display("FAIL basic_rec step%0d got %h want %h", i,
                         {ocyc[0], opc[0], oins[0], oa0[0]}, mq[0][0]);
            end
        end
        cpu_step = 1'b0;
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained got valid %b want 0", ov[0]);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bp_en  = 1'b0;
        rdy[1] = 1'b0;
        restart();
        for (int i = 0; i < 8; i++) begin
            set_step($urandom);
            tick();
            checks++;
            if (run[1] !== (i < 4) || tmo[1] !== (i >= 4)) begin
                errors++;
                $display("FAIL timeout_state step%0d got running %b timeout %b want %b %b",
                         i, run[1], tmo[1], i < 4, i >= 4);
            end
        end
        cpu_step = 1'b0;
        checks++;
        if (halt[1] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_halt got %b want 1", halt[1]);
        end
        rdy[1] = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && ov[1] === 1'b1; c++) begin
            checks++;
            if (ocyc[1] !== 16'(n) || {ocyc[1], opc[1], oins[1], oa0[1]} !== mq[1][0]) begin
                errors++;
                $display("FAIL timeout_rec idx%0d got cyc %0d want %0d", n, ocyc[1], n);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL timeout_count got %0d records want 5", n);
        end
        rdy[1] = 1'b0;
    endtask

    task automatic test_breakpoint();
        int n;
        logic [31:0] last_pc;
        rdy[0] = 1'b0;
        restart();
        bp_en = 1'b1;
        bp_pc = 32'h0000_000C;
        for (int i = 0; i < 5; i++) begin
            set_step(32'(i * 4));
            tick();
        end
        cpu_step = 1'b0;
        bp_en    = 1'b0;
        checks++;
        if (bph[0] !== 1'b1 || run[0] !== 1'b0 || tmo[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_flags got bp_hit %b running %b timeout %b want 1 0 0", bph[0], run[0], tmo[0]);
        end
        rdy[0]  = 1'b1;
        n       = 0;
        last_pc = 32'hFFFF_FFFF;
        for (int c = 0; c < 20 && ov[0] === 1'b1; c++) begin
            last_pc = opc[0];
            n++;
            tick();
        end
        checks++;
        if (n != 4 || last_pc !== 32'h0000_000C) begin
            errors++;
            $display("FAIL bp_records got %0d last pc %h want 4 last pc 0000000c", n, last_pc);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_full_stall();
        int n;
        rdy[2] = 1'b0;
        restart();
        for (int i = 0; i < 4; i++) begin
            set_step($urandom);
            tick();
        end
        checks++;
        if (halt[2] !== 1'b1 || run[2] !== 1'b1) begin
            errors++;
            $display("FAIL stall_full got halt %b running %b want 1 1", halt[2], run[2]);
        end
        set_step($urandom);
        tick();
        rdy[2] = 1'b1;
        tick();
        rdy[2] = 1'b0;
        checks++;
        if (halt[2] !== 1'b0 || ocyc[2] !== 16'd1) begin
            errors++;
            $display("FAIL stall_release got halt %b head cyc %0d want 0 1", halt[2], ocyc[2]);
        end
        tick();
        cpu_step = 1'b0;
        rdy[2]   = 1'b1;
        n        = 0;
        for (int c = 0; c < 20 && ov[2] === 1'b1; c++) begin
            checks++;
            if (ocyc[2] !== 16'(n + 1) || {ocyc[2], opc[2], oins[2], oa0[2]} !== mq[2][0]) begin
                errors++;
                $display("FAIL stall_rec idx%0d got cyc %0d want %0d", n, ocyc[2], n + 1);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL stall_count got %0d want 4", n);
        end
        rdy[2] = 1'b0;
    endtask

    task automatic test_drop();
        int n;
        int exp_c[4];
        exp_c  = '{1, 2, 3, 6};
        rdy[3] = 1'b0;
        restart();
        for (int i = 0; i < 6; i++) begin
            set_step($urandom);
            tick();
        end
        checks++;
        if (ovf[3] !== 1'b1 || halt[3] !== 1'b0 || ocyc[3] !== 16'd0) begin
            errors++;
            $display("FAIL drop_flag got overflow %b halt %b head %0d want 1 0 0", ovf[3], halt[3], ocyc[3]);
        end
        set_step($urandom);
        rdy[3] = 1'b1;
        tick();
        cpu_step = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && ov[3] === 1'b1; c++) begin
            checks++;
            if (n > 3 || ocyc[3] !== 16'(exp_c[n & 3]) || {ocyc[3], opc[3], oins[3], oa0[3]} !== mq[3][0]) begin
                errors++;
                $display("FAIL drop_rec idx%0d got cyc %0d want %0d", n, ocyc[3], exp_c[n & 3]);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL drop_count got %0d want 4", n);
        end
        rdy[3] = 1'b0;
    endtask

    task automatic test_clear();
        rdy[0] = 1'b0;
        restart();
        for (int i = 0; i < 3; i++) begin
            set_step(32'(16 + i * 4));
            bp_en = (i == 2);
            bp_pc = 32'd24;
            tick();
        end
        cpu_step = 1'b0;
        bp_en    = 1'b0;
        checks++;
        if (ov[0] !== 1'b1 || bph[0] !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre got valid %b bp_hit %b want 1 1", ov[0], bph[0]);
        end
        clear = 1'b1; arm = 1'b1; tick(); clear = 1'b0; arm = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || run[0] !== 1'b0 || halt[0] !== 1'b1 || bph[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_post got v%b r%b h%b b%b want v0 r0 h1 b0", ov[0], run[0], halt[0], bph[0]);
        end
        arm = 1'b1; tick(); arm = 1'b0;
        set_step(32'h40);
        tick();
        cpu_step = 1'b0;
        checks++;
        if (ov[0] !== 1'b1 || ocyc[0] !== 16'd0 || opc[0] !== 32'h40) begin
            errors++;
            $display("FAIL clear_rearm got v%b cyc %0d pc %h want v1 cyc 0 pc 40", ov[0], ocyc[0], opc[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            clear     = ($urandom_range(0, 59) == 0);
            arm       = ($urandom_range(0, 7) == 0);
            cpu_step  = ($urandom_range(0, 9) < 7);
            cpu_pc    = 32'($urandom_range(0, 15) * 4);
            cpu_instr = $urandom;
            cpu_a0    = $urandom;
            bp_en     = ($urandom_range(0, 3) == 0);
            bp_pc     = 32'($urandom_range(0, 15) * 4);
            for (int k = 0; k < N; k++) rdy[k] = ($urandom_range(0, 1) == 1);
            tick();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (ov[k] !== (mq[k].size() > 0) || halt[k] !== m_halt(k) || run[k] !== (m_st[k] == 1) ||
                    tmo[k] !== m_to[k] || bph[k] !== m_bp[k] || ovf[k] !== m_ov[k]) begin
                    errors++;
                    $display("FAIL rand_ctl cyc%0d dut%0d got v%b h%b r%b t%b b%b o%b want v%b h%b r%b t%b b%b o%b",
                             i, k, ov[k], halt[k], run[k], tmo[k], bph[k], ovf[k],
                             mq[k].size() > 0, m_halt(k), m_st[k] == 1, m_to[k], m_bp[k], m_ov[k]);
                end
                if (mq[k].size() > 0) begin
                    checks++;
                    if ({ocyc[k], opc[k], oins[k], oa0[k]} !== mq[k][0]) begin
                        errors++;
                        $display("FAIL rand_head cyc%0d dut%0d got %h want %h", i, k,
                                 {ocyc[k], opc[k], oins[k], oa0[k]}, mq[k][0]);
                    end
                end
            end
        end
        rst = 1'b0; clear = 1'b0; arm = 1'b0; cpu_step = 1'b0; bp_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; clear = 1'b0; cpu_step = 1'b0; bp_en = 1'b0;
        cpu_pc = 32'd0; cpu_instr = 32'd0; cpu_a0 = 32'd0; bp_pc = 32'd0;
        for (int k = 0; k < N; k++) begin
            rdy[k]   = 1'b0;
            m_st[k]  = 0;
            m_cyc[k] = 16'd0;
            m_to[k]  = 1'b0;
            m_bp[k]  = 1'b0;
            m_ov[k]  = 1'b0;
        end
        test_reset();
        test_basic();
        test_timeout();
        test_breakpoint();
        test_full_stall();
        test_drop();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
